// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end sharing one 64-bit integer ALU.
// Each requester owns a one-deep response slot. Unsupported opcodes are
// flagged with resp_err and a zeroed result.

module alu_64_bit_slim (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    output logic [63:0] result
);
    // Pure combinational ALU; shift amount is the low five bits of b.
    always_comb begin
        result = '0;
        case ({funct7, funct3})
            4'b0000: result = a + b;
            4'b1000: result = a - b;
            4'b0001: result = a << b[4:0];
            4'b0010: result = {63'd0, $signed(a) < $signed(b)};
            4'b0011: result = {63'd0, a < b};
            4'b0100: result = a ^ b;
            4'b0101: result = a >> b[4:0];
            4'b1101: result = $signed(a) >>> b[4:0];
            4'b0110: result = a | b;
            4'b0111: result = a & b;
            default: result = '0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [63:0]      req_rs1_0,
    input  logic [63:0]      req_rs2_0,
    input  logic [2:0]       req_funct3_0,
    input  logic             req_funct7_0,
    input  logic [TAG_W-1:0] req_tag_0,
    output logic             resp_valid_0,
    input  logic             resp_ready_0,
    output logic [63:0]      resp_data_0,
    output logic [TAG_W-1:0] resp_tag_0,
    output logic             resp_err_0,
    output logic [CNT_W-1:0] grant_cnt_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [63:0]      req_rs1_1,
    input  logic [63:0]      req_rs2_1,
    input  logic [2:0]       req_funct3_1,
    input  logic             req_funct7_1,
    input  logic [TAG_W-1:0] req_tag_1,
    output logic             resp_valid_1,
    input  logic             resp_ready_1,
    output logic [63:0]      resp_data_1,
    output logic [TAG_W-1:0] resp_tag_1,
    output logic             resp_err_1,
    output logic [CNT_W-1:0] grant_cnt_1
);

    // Requester fields gathered into indexable vectors so both slots share one body.
    logic [1:0]             req_valid_v;
    logic [1:0]             resp_ready_v;
    logic [1:0][63:0]       rs1_v;
    logic [1:0][63:0]       rs2_v;
    logic [1:0][2:0]        funct3_v;
    logic [1:0]             funct7_v;
    logic [1:0][TAG_W-1:0]  tag_v;

    assign req_valid_v  = {req_valid_1, req_valid_0};
    assign resp_ready_v = {resp_ready_1, resp_ready_0};
    assign rs1_v        = {req_rs1_1, req_rs1_0};
    assign rs2_v        = {req_rs2_1, req_rs2_0};
    assign funct3_v     = {req_funct3_1, req_funct3_0};
    assign funct7_v     = {req_funct7_1, req_funct7_0};
    assign tag_v        = {req_tag_1, req_tag_0};

    logic [1:0]             resp_valid_reg;
    logic [1:0][63:0]       resp_data_reg;
    logic [1:0][TAG_W-1:0]  resp_tag_reg;
    logic [1:0]             resp_err_reg;
    logic [1:0][CNT_W-1:0]  grant_cnt_reg;
    logic                   last_grant_reg;

    logic [1:0] eligible;
    logic [1:0] grant;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            // A slot can take a new result when empty or draining this cycle.
            assign eligible[gi] = req_valid_v[gi] & ~rst
                                & (~resp_valid_reg[gi] | resp_ready_v[gi]);
        end
    endgenerate

    // Round-robin pick: on contention the requester that did not win last time goes.
    always_comb begin
        grant = 2'b00;
        if (eligible[0] && eligible[1])
            grant = last_grant_reg ? 2'b01 : 2'b10;
        else
            grant = eligible;
    end

    assign req_ready_0 = grant[0];
    assign req_ready_1 = grant[1];

    // Shared ALU input mux; requester 0 fields are driven when idle (result unused).
    logic        sel;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [63:0] alu_result;
    logic        op_supported;

    assign sel        = grant[1];
    assign alu_a      = rs1_v[sel];
    assign alu_b      = rs2_v[sel];
    assign alu_funct3 = funct3_v[sel];
    assign alu_funct7 = funct7_v[sel];

    alu_64_bit_slim u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .funct3 (alu_funct3),
        .funct7 (alu_funct7),
        .result (alu_result)
    );

    // funct7 is only meaningful for SUB and SRA; every other pairing is rejected.
    always_comb begin
        case ({alu_funct7, alu_funct3})
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: op_supported = 1'b1;
            default:                                     op_supported = 1'b0;
        endcase
    end

    // Round-robin pointer moves only when something is granted.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant_reg <= 1'b1;
        else if (grant != 2'b00)
            last_grant_reg <= grant[1];
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [CNT_W-1:0] grant_cnt_next;
            assign grant_cnt_next = (grant_cnt_reg[gi] == {CNT_W{1'b1}})
                                  ? grant_cnt_reg[gi] : grant_cnt_reg[gi] + 1'b1;

            // Response slot: load on grant (wins over a same-cycle drain), else drain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    resp_valid_reg[gi] <= 1'b0;
                    resp_data_reg[gi]  <= '0;
                    resp_tag_reg[gi]   <= '0;
                    resp_err_reg[gi]   <= 1'b0;
                    grant_cnt_reg[gi]  <= '0;
                end else if (grant[gi]) begin
                    resp_valid_reg[gi] <= 1'b1;
                    resp_data_reg[gi]  <= op_supported ? alu_result : 64'd0;
                    resp_tag_reg[gi]   <= tag_v[gi];
                    resp_err_reg[gi]   <= ~op_supported;
                    grant_cnt_reg[gi]  <= grant_cnt_next;
                end else if (resp_valid_reg[gi] && resp_ready_v[gi]) begin
                    resp_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign resp_valid_0 = resp_valid_reg[0];
    assign resp_data_0  = resp_data_reg[0];
    assign resp_tag_0   = resp_tag_reg[0];
    assign resp_err_0   = resp_err_reg[0];
    assign grant_cnt_0  = grant_cnt_reg[0];
    assign resp_valid_1 = resp_valid_reg[1];
    assign resp_data_1  = resp_data_reg[1];
    assign resp_tag_1   = resp_tag_reg[1];
    assign resp_err_1   = resp_err_reg[1];
    assign grant_cnt_1  = grant_cnt_reg[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized, model-checked bench for alu_share_arbiter (built with CNT_W=4
// so counter saturation is reachable quickly).

module tb_alu_share_arbiter;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic req_valid_0, req_valid_1, resp_ready_0, resp_ready_1;
    logic [63:0] req_rs1_0, req_rs2_0, req_rs1_1, req_rs2_1;
    logic [2:0] req_funct3_0, req_funct3_1;
    logic req_funct7_0, req_funct7_1;
    logic [TAG_W-1:0] req_tag_0, req_tag_1;
    logic req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_err_0, resp_err_1;
    logic [63:0] resp_data_0, resp_data_1;
    logic [TAG_W-1:0] resp_tag_0, resp_tag_1;
    logic [CNT_W-1:0] grant_cnt_0, grant_cnt_1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_rs1_0(req_rs1_0), .req_rs2_0(req_rs2_0),
        .req_funct3_0(req_funct3_0), .req_funct7_0(req_funct7_0), .req_tag_0(req_tag_0),
        .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
        .resp_data_0(resp_data_0), .resp_tag_0(resp_tag_0), .resp_err_0(resp_err_0),
        .grant_cnt_0(grant_cnt_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_rs1_1(req_rs1_1), .req_rs2_1(req_rs2_1),
        .req_funct3_1(req_funct3_1), .req_funct7_1(req_funct7_1), .req_tag_1(req_tag_1),
        .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_data_1(resp_data_1), .resp_tag_1(resp_tag_1), .resp_err_1(resp_err_1),
        .grant_cnt_1(grant_cnt_1)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model state.
    logic             exp_valid [2];
    logic [63:0]      exp_data  [2];
    logic [TAG_W-1:0] exp_tag   [2];
    logic             exp_err   [2];
    int               exp_cnt   [2];
    int               exp_last;

    // Behavioural ALU: returns result and flags unknown opcodes.
    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b, output logic err);
        int sh;
        sh = int'(b % 32);
        err = 1'b0;
        case (op)
            4'd0:  return a + b;
            4'd8:  return a - b;
            4'd1:  return a << sh;
            4'd2:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd3:  return (a < b) ? 64'd1 : 64'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd13: return $signed(a) >>> sh;
            4'd6:  return a | b;
            4'd7:  return a & b;
            default: begin err = 1'b1; return 64'd0; end
        endcase
    endfunction

    // Which requester the rules say should be accepted this cycle.
    function automatic logic [1:0] exp_grant();
        bit e0, e1;
        e0 = !rst && req_valid_0 && (!exp_valid[0] || resp_ready_0);
        e1 = !rst && req_valid_1 && (!exp_valid[1] || resp_ready_1);
        if (e0 && e1) return (exp_last == 1) ? 2'b01 : 2'b10;
        return {e1, e0};
    endfunction

    function automatic logic [147:0] pack_obs();
        return {resp_valid_1, resp_valid_0, resp_data_1, resp_data_0, resp_tag_1, resp_tag_0,
                resp_err_1, resp_err_0, grant_cnt_1, grant_cnt_0};
    endfunction

    function automatic logic [147:0] pack_exp();
        return {exp_valid[1], exp_valid[0], exp_data[1], exp_data[0], exp_tag[1], exp_tag[0],
                exp_err[1], exp_err[0], CNT_W'(exp_cnt[1]), CNT_W'(exp_cnt[0])};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            exp_valid[n] = 0; exp_data[n] = 0; exp_tag[n] = 0; exp_err[n] = 0; exp_cnt[n] = 0;
        end
        exp_last = 1;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic tick();
        logic [1:0] g;
        logic e;
        g = exp_grant();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (g[0]) begin
                exp_data[0] = alu_ref({req_funct7_0, req_funct3_0}, req_rs1_0, req_rs2_0, e);
                exp_err[0] = e; exp_tag[0] = req_tag_0; exp_valid[0] = 1;
                if (exp_cnt[0] < 2**CNT_W - 1) exp_cnt[0]++;
                $display("accept r0 op=%h tag=%h", {req_funct7_0, req_funct3_0}, req_tag_0);
            end else if (exp_valid[0] && resp_ready_0) exp_valid[0] = 0;
            if (g[1]) begin
                exp_data[1] = alu_ref({req_funct7_1, req_funct3_1}, req_rs1_1, req_rs2_1, e);
                exp_err[1] = e; exp_tag[1] = req_tag_1; exp_valid[1] = 1;
                if (exp_cnt[1] < 2**CNT_W - 1) exp_cnt[1]++;
                $display("accept r1 op=%h tag=%h", {req_funct7_1, req_funct3_1}, req_tag_1);
            end else if (exp_valid[1] && resp_ready_1) exp_valid[1] = 0;
            if (g != 2'b00) exp_last = g[1] ? 1 : 0;
        end
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
        if (n == 0) begin
            req_valid_0 = v; req_funct7_0 = op[3]; req_funct3_0 = op[2:0];
            req_rs1_0 = a; req_rs2_0 = b; req_tag_0 = t;
        end else begin
            req_valid_1 = v; req_funct7_1 = op[3]; req_funct3_1 = op[2:0];
            req_rs1_1 = a; req_rs2_1 = b; req_tag_1 = t;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; set_req(0, 1, 4'd0, 64'd1, 64'd1, 4'd1); set_req(1, 1, 4'd0, 64'd1, 64'd1, 4'd1);
        resp_ready_0 = 1; resp_ready_1 = 1;
        #1;
        n_total++;
        if ({req_ready_1, req_ready_0} !== 2'b00) $display("FAIL reset_ready got=%b want=00", {req_ready_1, req_ready_0});
        else n_pass++;
        tick();
        n_total++;
        if (pack_obs() !== 148'd0) $display("FAIL reset_state got=%h want=0", pack_obs());
        else n_pass++;
        @(negedge clk);
        rst = 0; set_req(0, 0, 4'd0, 0, 0, 0); set_req(1, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_single_add();
        @(negedge clk);
        set_req(0, 1, 4'd0, 64'd5, 64'd7, 4'd3); resp_ready_0 = 1;
        #1;
        n_total++;
        if ({req_ready_1, req_ready_0} !== 2'b01) $display("FAIL add_ready got=%b want=01", {req_ready_1, req_ready_0});
        else n_pass++;
        tick();
        n_total++;
        if ({resp_valid_0, resp_data_0, resp_tag_0, resp_err_0, grant_cnt_0} !== {1'b1, 64'd12, 4'd3, 1'b0, 4'd1})
            $display("FAIL add_result got v=%b d=%0d t=%0d e=%b c=%0d want v=1 d=12 t=3 e=0 c=1",
                     resp_valid_0, resp_data_0, resp_tag_0, resp_err_0, grant_cnt_0);
        else n_pass++;
        @(negedge clk);
        set_req(0, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] prev;
        prev = 2'b00;
        @(negedge clk);
        set_req(0, 1, 4'd8, 64'd10, 64'd3, 4'd5); set_req(1, 1, 4'd3, 64'd1, 64'd2, 4'd6);
        resp_ready_0 = 1; resp_ready_1 = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_total++;
            if ({req_ready_1, req_ready_0} !== exp_grant() || {req_ready_1, req_ready_0} == prev)
                $display("FAIL contention_grant cyc=%0d got=%b want=%b", i, {req_ready_1, req_ready_0}, exp_grant());
            else n_pass++;
            prev = {req_ready_1, req_ready_0};
            tick();
            n_total++;
            if (pack_obs() !== pack_exp()) $display("FAIL contention_out cyc=%0d got=%h want=%h", i, pack_obs(), pack_exp());
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if ({resp_data_0, resp_data_1} !== {64'd7, 64'd1})
            $display("FAIL contention_data got=%0d,%0d want=7,1", resp_data_0, resp_data_1);
        else n_pass++;
        set_req(0, 0, 4'd0, 0, 0, 0); set_req(1, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        resp_ready_1 = 0; resp_ready_0 = 1;
        set_req(1, 1, 4'd4, 64'hF0, 64'h0F, 4'd9);
        tick();
        @(negedge clk);
        set_req(0, 1, 4'd6, 64'h100, 64'h1, 4'd2);
        set_req(1, 1, 4'd7, 64'hFF, 64'h3, 4'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if ({req_ready_1, req_ready_0} !== 2'b01) $display("FAIL bp_ready cyc=%0d got=%b want=01", i, {req_ready_1, req_ready_0});
            else n_pass++;
            tick();
            n_total++;
            if (pack_obs() !== pack_exp()) $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, pack_obs(), pack_exp());
            else n_pass++;
            @(negedge clk);
        end
        resp_ready_1 = 1;
        #1;
        n_total++;
        if ({req_ready_1, req_ready_0} !== 2'b10) $display("FAIL bp_release got=%b want=10", {req_ready_1, req_ready_0});
        else n_pass++;
        tick();
        n_total++;
        if ({resp_valid_1, resp_data_1, resp_tag_1} !== {1'b1, 64'h3, 4'd4} || pack_obs() !== pack_exp())
            $display("FAIL bp_reload got=%h want=%h", pack_obs(), pack_exp());
        else n_pass++;
        @(negedge clk);
        set_req(0, 0, 4'd0, 0, 0, 0); set_req(1, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        resp_ready_0 = 1;
        set_req(0, 1, 4'b1010, 64'd55, 64'd66, 4'hA);
        tick();
        n_total++;
        if ({resp_valid_0, resp_err_0, resp_data_0, resp_tag_0} !== {1'b1, 1'b1, 64'd0, 4'hA})
            $display("FAIL illegal got e=%b d=%h t=%h want e=1 d=0 t=a", resp_err_0, resp_data_0, resp_tag_0);
        else n_pass++;
        @(negedge clk);
        set_req(0, 1, 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 4'hB);
        tick();
        n_total++;
        if ({resp_err_0, resp_data_0, resp_tag_0} !== {1'b0, 64'hF800_0000_0000_0000, 4'hB})
            $display("FAIL sra got e=%b d=%h want e=0 d=f800000000000000", resp_err_0, resp_data_0);
        else n_pass++;
        @(negedge clk);
        set_req(0, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        resp_ready_0 = 0; resp_ready_1 = 0;
        set_req(0, 1, 4'd0, 64'd1, 64'd2, 4'd1); set_req(1, 1, 4'd0, 64'd3, 64'd4, 4'd2);
        tick(); @(negedge clk); tick(); @(negedge clk);
        n_total++;
        if ({resp_valid_1, resp_valid_0} !== 2'b11) $display("FAIL mid_full got=%b want=11", {resp_valid_1, resp_valid_0});
        else n_pass++;
        rst = 1; resp_ready_0 = 1; resp_ready_1 = 1;
        #1;
        n_total++;
        if ({req_ready_1, req_ready_0} !== 2'b00) $display("FAIL mid_rst_ready got=%b want=00", {req_ready_1, req_ready_0});
        else n_pass++;
        tick();
        n_total++;
        if (pack_obs() !== 148'd0) $display("FAIL mid_rst_state got=%h want=0", pack_obs());
        else n_pass++;
        @(negedge clk);
        rst = 0;
        #1;
        n_total++;
        if ({req_ready_1, req_ready_0} !== 2'b01) $display("FAIL mid_first_grant got=%b want=01", {req_ready_1, req_ready_0});
        else n_pass++;
        tick();
        @(negedge clk);
        set_req(0, 0, 4'd0, 0, 0, 0); set_req(1, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        resp_ready_0 = 1;
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1, 4'd0, 64'(i), 64'd1, 4'(i));
            tick();
            n_total++;
            if (pack_obs() !== pack_exp()) $display("FAIL sat_step i=%0d got=%h want=%h", i, pack_obs(), pack_exp());
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (grant_cnt_0 !== 4'd15) $display("FAIL sat_hold got=%0d want=15", grant_cnt_0);
        else n_pass++;
        set_req(0, 0, 4'd0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                a = {$urandom, $urandom};
                b = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 80));
                set_req(n, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a, b, 4'($urandom));
            end
            resp_ready_0 = 1'($urandom_range(0, 2) != 0);
            resp_ready_1 = 1'($urandom_range(0, 2) != 0);
            #1;
            n_total++;
            if ({req_ready_1, req_ready_0} !== exp_grant())
                $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, {req_ready_1, req_ready_0}, exp_grant());
            else n_pass++;
            tick();
            n_total++;
            if (pack_obs() !== pack_exp()) $display("FAIL rand_out cyc=%0d got=%h want=%h", i, pack_obs(), pack_exp());
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1; resp_ready_0 = 0; resp_ready_1 = 0;
        set_req(0, 0, 4'd0, 0, 0, 0); set_req(1, 0, 4'd0, 0, 0, 0);
        model_reset();
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
